// File: rtl/regfile_write_arbiter_pkg.sv
// Shared sizes and helpers for the register-file write arbiter.
// Holds the requester count, address/data widths and the enabled 5-to-32 decoder.
package regfile_write_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int REG_AW  = 5;
  localparam int DATA_W  = 32;
  localparam int CNT_W   = 16;
  localparam int IDX_W   = 2;

  // Enabled 5-to-32 decoder shared with the rest of the register-file logic.
  function automatic logic [31:0] decode_5to32(input logic en, input logic [4:0] addr);
    logic [31:0] onehot;
    onehot = '0;
    if (en) begin
      onehot[addr] = 1'b1;
    end
    return onehot;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_pick4.sv
// Four-way round-robin picker: one-hot grant for the first valid requester
// found when searching upward from the requester after last.
module rr_pick4 (
  input  logic [3:0] valid,
  input  logic [1:0] last,
  output logic [3:0] grant
);

  logic [1:0] idx;

  // Walk from the farthest candidate (last itself) to the nearest (last+1),
  // so the nearest valid requester overwrites any farther one.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (valid[idx]) begin
        grant = '0;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter funnelling four write requesters into one register-file
// write port, with a registered write stage and a saturating conflict counter.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_W  = regfile_write_arbiter_pkg::DATA_W,
  parameter int NUM_REQ = regfile_write_arbiter_pkg::NUM_REQ
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        stall,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*REG_AW-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        wr_en,
  output logic [REG_AW-1:0]           wr_addr,
  output logic [DATA_W-1:0]           wr_data,
  output logic [31:0]                 wr_onehot,
  output logic [CNT_W-1:0]            conflict_count
);

  logic [IDX_W-1:0]   last_grant_reg;
  logic               wr_en_reg;
  logic [REG_AW-1:0]  wr_addr_reg;
  logic [DATA_W-1:0]  wr_data_reg;
  logic [CNT_W-1:0]   conflict_count_reg;

  logic [NUM_REQ-1:0] pick;
  logic [NUM_REQ-1:0] grant;
  logic               transfer;
  logic               conflict;
  logic [IDX_W-1:0]   grant_idx;
  logic [REG_AW-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;

  logic [REG_AW-1:0]  addr_slot [NUM_REQ];
  logic [DATA_W-1:0]  data_slot [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_slot[gi] = req_addr[gi*REG_AW +: REG_AW];
      assign data_slot[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  rr_pick4 u_pick (
    .valid (req_valid),
    .last  (last_grant_reg),
    .grant (pick)
  );

  assign grant     = (stall || reset) ? '0 : pick;
  assign req_ready = grant;
  assign transfer  = |grant;
  // Two or more bits set: clearing the lowest set bit leaves something behind.
  assign conflict  = (req_valid & (req_valid - 1'b1)) != '0;

  always_comb begin
    grant_idx = '0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_idx = IDX_W'(i);
        sel_addr  = addr_slot[i];
        sel_data  = data_slot[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_reg     <= IDX_W'(NUM_REQ - 1);
      wr_en_reg          <= 1'b0;
      wr_addr_reg        <= '0;
      wr_data_reg        <= '0;
      conflict_count_reg <= '0;
    end else begin
      // Address 0 is accepted and advances priority but never writes.
      wr_en_reg <= transfer && (sel_addr != '0);
      if (transfer) begin
        last_grant_reg <= grant_idx;
        wr_addr_reg    <= sel_addr;
        wr_data_reg    <= sel_data;
      end
      if (conflict && (conflict_count_reg != '1)) begin
        conflict_count_reg <= conflict_count_reg + 1'b1;
      end
    end
  end

  // A write already in the output stage is squashed if reset arrives now.
  assign wr_en          = wr_en_reg & ~reset;
  assign wr_addr        = wr_addr_reg;
  assign wr_data        = wr_data_reg;
  assign wr_onehot      = decode_5to32(wr_en, wr_addr_reg);
  assign conflict_count = conflict_count_reg;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus random traffic,
// each cycle compared against a round-robin reference model.
module tb_regfile_write_arbiter;

  logic         clock;
  logic         reset;
  logic         stall;
  logic [3:0]   req_valid;
  logic [19:0]  req_addr;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         wr_en;
  logic [4:0]   wr_addr;
  logic [31:0]  wr_data;
  logic [31:0]  wr_onehot;
  logic [15:0]  conflict_count;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          m_last;
  logic        m_wr_en;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          m_cnt;

  regfile_write_arbiter dut (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_onehot      (wr_onehot),
    .conflict_count (conflict_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last  = 3;
    m_wr_en = 1'b0;
    m_addr  = '0;
    m_data  = '0;
    m_cnt   = 0;
  endtask

  // Index the model grants this cycle, or -1 for none.
  function automatic int model_pick();
    if (stall || reset || req_valid == 4'b0) return -1;
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (m_last + k) % 4;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic check_outputs(input string tag);
    logic [31:0] exp_onehot;
    exp_onehot = m_wr_en ? (32'h1 << m_addr) : 32'h0;
    check({tag, ".wr_en"}, {31'b0, wr_en}, {31'b0, m_wr_en});
    check({tag, ".wr_onehot"}, wr_onehot, exp_onehot);
    if (m_wr_en) begin
      check({tag, ".wr_addr"}, {27'b0, wr_addr}, {27'b0, m_addr});
      check({tag, ".wr_data"}, wr_data, m_data);
    end
    check({tag, ".count"}, {16'b0, conflict_count}, m_cnt[31:0]);
  endtask

  // One clock of traffic: drive, check the grant, advance the model, check outputs.
  task automatic step(input string tag, input logic s, input logic [3:0] v,
                      input logic [19:0] a, input logic [127:0] d);
    int g;
    logic [3:0] exp_ready;
    stall = s; req_valid = v; req_addr = a; req_data = d;
    #1;
    g = model_pick();
    exp_ready = (g < 0) ? 4'b0 : (4'b1 << g);
    check({tag, ".ready"}, {28'b0, req_ready}, {28'b0, exp_ready});
    @(posedge clock);
    if (reset) begin
      model_reset();
    end else begin
      if (g >= 0) begin
        m_last  = g;
        m_addr  = a[g*5 +: 5];
        m_data  = d[g*32 +: 32];
        m_wr_en = (m_addr != 5'd0);
      end else begin
        m_wr_en = 1'b0;
      end
      if ($countones(v) >= 2 && m_cnt < 65535) m_cnt++;
    end
    #1;
    check_outputs(tag);
    $display("step %-8s rst=%0b stall=%0b valid=%b grant=%0d wr_en=%0b addr=%0d cnt=%0d",
             tag, reset, s, v, g, wr_en, wr_addr, conflict_count);
  endtask

  function automatic logic [127:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [19:0] rand_addr();
    logic [19:0] a;
    for (int i = 0; i < 4; i++) a[i*5 +: 5] = 5'($urandom_range(0, 31));
    return a;
  endfunction

  initial begin
    reset = 1'b1; stall = 1'b0; req_valid = 4'b0; req_addr = '0; req_data = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("rst.ready", {28'b0, req_ready}, 32'h0);
    check_outputs("rst");
    check("rst.addr", {27'b0, wr_addr}, 32'h0);
    check("rst.data", wr_data, 32'h0);

    // Reset holds the grant at zero even with all requesters valid.
    step("rst_req", 1'b0, 4'b1111, rand_addr(), rand_data());
    reset = 1'b0;

    // All four requesters valid: grants rotate 0,1,2,3.
    for (int i = 0; i < 4; i++)
      step("rr4", 1'b0, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, rand_data());
    check("rr4.cnt4", {16'b0, conflict_count}, 32'd4);

    // Single requester 2 writing register 7.
    step("req2", 1'b0, 4'b0100, {5'd0, 5'd7, 5'd0, 5'd0}, {32'h0, 32'hDEADBEEF, 64'h0});
    check("req2.onehot_lit", wr_onehot, 32'h00000080);

    // Address 0 from requester 1: accepted, no write, priority advances to 1.
    step("addr0", 1'b0, 4'b0010, 20'h0, rand_data());
    step("after0", 1'b0, 4'b1111, {5'd9, 5'd9, 5'd9, 5'd9}, rand_data());

    // Stall for three cycles, then resume round-robin.
    for (int i = 0; i < 3; i++)
      step("stall", 1'b1, 4'b0101, {5'd11, 5'd12, 5'd13, 5'd14}, rand_data());
    step("unstall", 1'b0, 4'b0101, {5'd11, 5'd12, 5'd13, 5'd14}, rand_data());
    step("unstall2", 1'b0, 4'b0101, {5'd11, 5'd12, 5'd13, 5'd14}, rand_data());

    // Reset pulsed while a write to register 5 sits in the output stage.
    step("pre_rst", 1'b0, 4'b0100, {5'd0, 5'd5, 5'd0, 5'd0}, rand_data());
    step("pre_rst2", 1'b0, 4'b1000, {5'd5, 5'd0, 5'd0, 5'd0}, rand_data());
    reset = 1'b1; req_valid = 4'b0;
    #1;
    check("drop.wr_en", {31'b0, wr_en}, 32'h0);
    check("drop.onehot", wr_onehot, 32'h0);
    @(posedge clock);
    model_reset();
    #1;
    check_outputs("drop");
    reset = 1'b0;
    step("post_rst", 1'b0, 4'b1111, {5'd1, 5'd2, 5'd3, 5'd4}, rand_data());

    // Random traffic with occasional stall and reset.
    for (int i = 0; i < 300; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      step("rand", ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
           rand_addr(), rand_data());
    end
    reset = 1'b0;

    // Drive the conflict counter up to saturation, then push past it.
    reset = 1'b1;
    step("sat_rst", 1'b0, 4'b0, 20'h0, 128'h0);
    reset = 1'b0;
    stall = 1'b1; req_valid = 4'b0011;
    for (int i = 0; i < 65535; i++) begin
      @(posedge clock);
      if (m_cnt < 65535) m_cnt++;
    end
    m_wr_en = 1'b0;
    #1;
    check("sat.preload", {16'b0, conflict_count}, 32'h0000FFFF);
    step("sat1", 1'b0, 4'b0011, {5'd0, 5'd0, 5'd3, 5'd2}, rand_data());
    step("sat2", 1'b0, 4'b0011, {5'd0, 5'd0, 5'd3, 5'd2}, rand_data());
    check("sat.hold", {16'b0, conflict_count}, 32'h0000FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, width of write data.
REQ-002 Parameter: NUM_REQ, 4, number of write requesters; fixed at 4; other values are unsupported.
REQ-003 Port: clock  in  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: stall  in  1  when high, no grant is issued this cycle.
REQ-006 Port: req_valid  in  4  bit i = requester i presents a write.
REQ-007 Port: req_addr  in  20  requester i destination register at [5i+4:5i].
REQ-008 Port: req_data  in  128  requester i data at [32i+31:32i].
REQ-009 Port: req_ready  out  4  one-hot grant; combinational, same cycle as the accepted request.
REQ-010 Port: wr_en  out  1  registered write strobe to the register file.
REQ-011 Port: wr_addr  out  5  registered write address.
REQ-012 Port: wr_data  out  32  registered write data.
REQ-013 Port: wr_onehot  out  32  registered decoded per-register write enable.
REQ-014 Port: conflict_count  out  16  saturating count of cycles with two or more valid requests.

Function
REQ-015 A transfer occurs for requester i when req_valid[i] and req_ready[i] are both high at a rising edge.
REQ-016 req_ready shall be all-zero when stall or reset is high, or when req_valid is zero; otherwise it shall have exactly one bit set.
REQ-017 Arbitration shall be round-robin: search order starts at (last_grant+1) mod 4 and wraps through 3 back to 0.
REQ-018 The granted requester is the first valid requester in that search order.
REQ-019 last_grant shall update to the granted index on every transfer and hold otherwise.
REQ-020 Requesters shall hold valid, addr and data stable until ready; the arbiter does not buffer requests that are not granted.
REQ-021 Latency: the cycle after a transfer, wr_addr and wr_data shall equal the granted request, and wr_en shall be 1.
REQ-022 In a cycle with no transfer, wr_en=0 and wr_onehot=0 next cycle; wr_addr and wr_data hold their previous values.
REQ-023 Address 0: the transfer is still accepted and last_grant still advances, but wr_en=0 and wr_onehot=0 next cycle.
REQ-024 wr_onehot shall equal (1 << wr_addr) when wr_en=1, and 0 otherwise.
REQ-025 conflict_count shall increment by 1 in each cycle with popcount(req_valid)>=2, regardless of stall.
REQ-026 conflict_count shall saturate at 16'hFFFF and never wrap.
REQ-027 When stall falls, arbitration resumes from the unchanged last_grant; no request is lost or duplicated.
REQ-028 Sustained throughput shall be one write per cycle with no bubbles between back-to-back transfers.

Reset
REQ-029 While reset is high: req_ready=0, wr_en=0, wr_onehot=0, wr_addr=0, wr_data=0, conflict_count=0.
REQ-030 While reset is high, last_grant shall be set to 3 so that requester 0 holds first priority after reset.
REQ-031 Reset asserted in the cycle after a transfer shall clear that cycle's output write, so the write is dropped.

Structure
REQ-032 A shared package shall hold NUM_REQ, REG_AW=5, DATA_W=32 and the conflict counter width of 16.
REQ-033 One combinational sub-module, rr_pick4, shall compute the one-hot grant from req_valid and last_grant.
REQ-034 wr_onehot shall be generated with the team's existing 5-to-32 enabled decoder, enabled by the registered wr_en.

Verification
REQ-035 Scenario: after reset, req_valid=4'b1111 held for 4 cycles -> grants 0,1,2,3 in order; conflict_count=4.
REQ-036 Scenario: only requester 2 valid, addr=7, data=32'hDEADBEEF -> next cycle wr_en=1, wr_addr=7, wr_onehot=32'h00000080.
REQ-037 Scenario: requester 1 valid with addr=0 -> req_ready=4'b0010; next cycle wr_en=0, wr_onehot=0; last_grant=1.
REQ-038 Scenario: stall=1 for 3 cycles with req_valid=4'b0101 -> req_ready=0 and wr_en=0 throughout; after stall falls, the grant follows round-robin order.
REQ-039 Scenario: conflict_count preloaded via 65535 conflict cycles, then 2 more -> value stays 16'hFFFF.
REQ-040 Scenario: reset pulsed the cycle after a transfer to addr=5 -> wr_en=0, wr_onehot=0; next grant goes to requester 0.
